decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 59 +++++
 rtl/decode_stage_reg_file.sv | 36 +++
 rtl/decode_stage.sv | 123 ++++++++++++
 tb/tb_decode_stage.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared constants and instruction classification for the decode stage.
// Opcode/funct values follow the standard MIPS-I encodings.
package decode_stage_pkg;

  localparam logic [31:0] PC_START_DEFAULT = 32'h0000_3000;
  localparam int          NUM_REGS         = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  typedef enum logic [3:0] {
    INS_NOP, INS_ADDU, INS_SUBU, INS_ORI, INS_LUI, INS_LW,
    INS_SW, INS_BEQ, INS_J, INS_JAL, INS_JR
  } instr_e;

  typedef struct packed {
    instr_e kind;
    logic   reads_rs;
    logic   reads_rt;
  } decoded_t;

  // Unsupported encodings fall through as a nop that reads nothing.
  function automatic decoded_t decode(input logic [31:0] instr);
    decoded_t d;
    d.kind     = INS_NOP;
    d.reads_rs = 1'b0;
    d.reads_rt = 1'b0;
    case (instr[31:26])
      OP_RTYPE: begin
        case (instr[5:0])
          FN_ADDU: begin d.kind = INS_ADDU; d.reads_rs = 1'b1; d.reads_rt = 1'b1; end
          FN_SUBU: begin d.kind = INS_SUBU; d.reads_rs = 1'b1; d.reads_rt = 1'b1; end
          FN_JR:   begin d.kind = INS_JR;   d.reads_rs = 1'b1; end
          default: ;
        endcase
      end
      OP_ORI:  begin d.kind = INS_ORI; d.reads_rs = 1'b1; end
      OP_LUI:  d.kind = INS_LUI;
      OP_LW:   begin d.kind = INS_LW;  d.reads_rs = 1'b1; end
      OP_SW:   begin d.kind = INS_SW;  d.reads_rs = 1'b1; d.reads_rt = 1'b1; end
      OP_BEQ:  begin d.kind = INS_BEQ; d.reads_rs = 1'b1; d.reads_rt = 1'b1; end
      OP_J:    d.kind = INS_J;
      OP_JAL:  d.kind = INS_JAL;
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// 32x32 register file: one write port, two read ports, optional write-through
// so a value written this cycle is visible to reads in the same cycle.
module reg_file
  import decode_stage_pkg::*;
#(
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rd_addr_a,
  output logic [31:0] rd_data_a,
  input  logic [4:0]  rd_addr_b,
  output logic [31:0] rd_data_b,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data
);

  logic [31:0] regs [NUM_REGS];

  // NOTE: the array is built from flops, not a RAM macro, so it can and must be
  // cleared by reset; a RAM-based file could not be reset in one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en && wr_addr != 5'd0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = (rd_addr_a == 5'd0) ? '0 :
                     (WB_BYPASS && wr_en && wr_addr == rd_addr_a) ? wr_data : regs[rd_addr_a];
  assign rd_data_b = (rd_addr_b == 5'd0) ? '0 :
                     (WB_BYPASS && wr_en && wr_addr == rd_addr_b) ? wr_data : regs[rd_addr_b];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: IF/ID register, hazard stall, operand forwarding, delayed-branch
// redirect resolution and the ID/EX register.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter logic [31:0] PC_START  = PC_START_DEFAULT,
  parameter bit          WB_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  input  logic        ex_we,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic        mem_we,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        isBranch,
  output logic [31:0] branchAddr,
  output logic        isJump,
  output logic [25:0] jumpAddr,
  output logic        isJumpReg,
  output logic [31:0] jumpRegAddr,
  output logic        stall,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_rs_data,
  output logic [31:0] id_rt_data,
  output logic [31:0] id_imm_ext
);

  logic [31:0] ifid_pc, ifid_instr;
  decoded_t    dec;
  logic [4:0]  rs, rt;
  logic [15:0] imm16;
  logic [31:0] imm_sext, imm_ext;
  logic [31:0] rf_rs, rf_rt, rs_val, rt_val;
  logic        ex_hit, is_ctrl_read;

  assign dec      = decode(ifid_instr);
  assign rs       = ifid_instr[25:21];
  assign rt       = ifid_instr[20:16];
  assign imm16    = ifid_instr[15:0];
  assign imm_sext = {{16{imm16[15]}}, imm16};

  reg_file #(.WB_BYPASS(WB_BYPASS)) u_reg_file (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_a (rs),
    .rd_data_a (rf_rs),
    .rd_addr_b (rt),
    .rd_data_b (rf_rt),
    .wr_en     (wb_we),
    .wr_addr   (wb_addr),
    .wr_data   (wb_data)
  );

  // MEM beats the register file's WB bypass; $0 is already zero from reg_file.
  assign rs_val = (rs != 5'd0 && mem_we && mem_rd == rs) ? mem_data : rf_rs;
  assign rt_val = (rt != 5'd0 && mem_we && mem_rd == rt) ? mem_data : rf_rt;

  assign ex_hit = (ex_rd != 5'd0) &&
                  ((dec.reads_rs && ex_rd == rs) || (dec.reads_rt && ex_rd == rt));
  assign is_ctrl_read = (dec.kind == INS_BEQ) || (dec.kind == INS_JR);
  // beq/jr compare in ID, so any EX producer (not just loads) must be waited out.
  assign stall  = ex_hit && (ex_is_load || (ex_we && is_ctrl_read));

  assign isBranch    = (dec.kind == INS_BEQ) && (rs_val == rt_val) && !stall;
  assign branchAddr  = imm_sext;
  assign isJump      = (dec.kind == INS_J || dec.kind == INS_JAL) && !stall;
  assign jumpAddr    = ifid_instr[25:0];
  assign isJumpReg   = (dec.kind == INS_JR) && !stall;
  assign jumpRegAddr = rs_val;

  // NOTE: every combinational output gets a default before the case, otherwise
  // the unlisted kinds would hold the old value and infer a latch.
  always_comb begin
    imm_ext = '0;
    case (dec.kind)
      INS_ORI:                 imm_ext = {16'h0000, imm16};
      INS_LUI:                 imm_ext = {imm16, 16'h0000};
      INS_LW, INS_SW, INS_BEQ: imm_ext = imm_sext;
      default: ;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ifid_pc    <= PC_START;
      ifid_instr <= '0;
    end else if (!stall) begin
      ifid_pc    <= if_pc;
      ifid_instr <= if_instr;
    end
  end

  // A stall and a reset both leave an all-zero, invalid ID/EX entry.
  always_ff @(posedge clk) begin
    if (!reset || stall) begin
      id_valid   <= 1'b0;
      id_pc      <= '0;
      id_instr   <= '0;
      id_rs_data <= '0;
      id_rt_data <= '0;
      id_imm_ext <= '0;
    end else begin
      id_valid   <= 1'b1;
      id_pc      <= ifid_pc;
      id_instr   <= ifid_instr;
      id_rs_data <= rs_val;
      id_rt_data <= (dec.kind == INS_JAL) ? ifid_pc + 32'd8 : rt_val;
      id_imm_ext <= imm_ext;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Randomized plus directed bench for decode_stage with a queue-based scoreboard
// fed by a behavioural model of the decode rules.
module tb_decode_stage;

  localparam logic [31:0] PC_START = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc, if_instr;
  logic        ex_we, ex_is_load;
  logic [4:0]  ex_rd;
  logic        mem_we;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        isBranch, isJump, isJumpReg, stall, id_valid;
  logic [31:0] branchAddr, jumpRegAddr;
  logic [25:0] jumpAddr;
  logic [31:0] id_pc, id_instr, id_rs_data, id_rt_data, id_imm_ext;

  always #5 clk = ~clk;

  decode_stage #(.PC_START(PC_START), .WB_BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_instr(if_instr),
    .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .isBranch(isBranch), .branchAddr(branchAddr), .isJump(isJump), .jumpAddr(jumpAddr),
    .isJumpReg(isJumpReg), .jumpRegAddr(jumpRegAddr), .stall(stall),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm_ext(id_imm_ext)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic rst; logic [31:0] pc, instr;
    logic ex_we, ex_ld; logic [4:0] ex_rd;
    logic m_we; logic [4:0] m_rd; logic [31:0] m_data;
    logic w_we; logic [4:0] w_addr; logic [31:0] w_data;
  } stim_t;

  typedef struct {
    logic full; logic valid; logic [31:0] pc, instr, rs, rt, imm;
  } idex_t;

  idex_t       exp_q[$];
  idex_t       mon_e;
  logic [31:0] m_rf [32];
  logic [31:0] m_pc, m_instr;
  bit          known = 0;
  logic [31:0] fetch_pc = PC_START;
  stim_t       s;

  // Reference model: mnemonic-level view of the instruction in ID.
  function automatic string mnem(input logic [31:0] i);
    case (i[31:26])
      6'h00: begin
        if (i[5:0] == 6'h21) return "addu";
        if (i[5:0] == 6'h23) return "subu";
        if (i[5:0] == 6'h08) return "jr";
        return "nop";
      end
      6'h0D: return "ori";
      6'h0F: return "lui";
      6'h23: return "lw";
      6'h2B: return "sw";
      6'h04: return "beq";
      6'h02: return "j";
      6'h03: return "jal";
      default: return "nop";
    endcase
  endfunction

  function automatic logic [31:0] fwd(input stim_t st, input logic [4:0] r);
    if (r == 0) return 32'h0;
    if (st.m_we && st.m_rd == r) return st.m_data;
    if (st.w_we && st.w_addr == r) return st.w_data;
    return m_rf[r];
  endfunction

  task automatic run(input stim_t st);
    string       m;
    logic [4:0]  rs, rt;
    logic [31:0] rsv, rtv, sext, imm;
    bit          rd_rs, rd_rt, hit, e_stall;
    idex_t       e;
    @(negedge clk);
    #1;
    reset = st.rst; if_pc = st.pc; if_instr = st.instr;
    ex_we = st.ex_we; ex_is_load = st.ex_ld; ex_rd = st.ex_rd;
    mem_we = st.m_we; mem_rd = st.m_rd; mem_data = st.m_data;
    wb_we = st.w_we; wb_addr = st.w_addr; wb_data = st.w_data;
    #1;
    e_stall = 0;
    if (known) begin
      m     = mnem(m_instr);
      rs    = m_instr[25:21];
      rt    = m_instr[20:16];
      rd_rs = (m == "addu" || m == "subu" || m == "sw" || m == "beq" ||
               m == "ori" || m == "lw" || m == "jr");
      rd_rt = (m == "addu" || m == "subu" || m == "sw" || m == "beq");
      hit   = st.ex_rd != 0 && ((rd_rs && rs == st.ex_rd) || (rd_rt && rt == st.ex_rd));
      e_stall = hit && (st.ex_ld || (st.ex_we && (m == "beq" || m == "jr")));
      rsv  = fwd(st, rs);
      rtv  = fwd(st, rt);
      sext = 32'($signed(m_instr[15:0]));
      check("stall", 32'(stall), 32'(e_stall));
      check("isBranch", 32'(isBranch), 32'(m == "beq" && rsv == rtv && !e_stall));
      check("branchAddr", branchAddr, sext);
      check("isJump", 32'(isJump), 32'((m == "j" || m == "jal") && !e_stall));
      check("jumpAddr", 32'(jumpAddr), 32'(m_instr[25:0]));
      check("isJumpReg", 32'(isJumpReg), 32'(m == "jr" && !e_stall));
      check("jumpRegAddr", jumpRegAddr, rsv);
      if (m == "ori") imm = {16'h0, m_instr[15:0]};
      else if (m == "lui") imm = {m_instr[15:0], 16'h0};
      else if (m == "lw" || m == "sw" || m == "beq") imm = sext;
      else imm = 32'h0;
      e = '{full: 1'b1, valid: 1'b1, pc: m_pc, instr: m_instr, rs: rsv,
            rt: (m == "jal") ? m_pc + 32'd8 : rtv, imm: imm};
    end
    if (!st.rst) begin
      exp_q.push_back('{full: 1'b1, valid: 1'b0, pc: 0, instr: 0, rs: 0, rt: 0, imm: 0});
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
      m_pc = PC_START; m_instr = 32'h0; known = 1;
    end else if (known) begin
      if (e_stall) exp_q.push_back('{full: 1'b0, valid: 1'b0, pc: 0, instr: 0, rs: 0, rt: 0, imm: 0});
      else exp_q.push_back(e);
      if (st.w_we && st.w_addr != 0) m_rf[st.w_addr] = st.w_data;
      if (!e_stall) begin m_pc = st.pc; m_instr = st.instr; end
    end
    fetch_pc = fetch_pc + 32'd4;
  endtask

  // Monitor: the ID/EX register presents one entry per cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("id_valid", 32'(id_valid), 32'(mon_e.valid));
      check("id_instr", id_instr, mon_e.instr);
      if (mon_e.full) begin
        check("id_pc", id_pc, mon_e.pc);
        check("id_rs_data", id_rs_data, mon_e.rs);
        check("id_rt_data", id_rt_data, mon_e.rt);
        check("id_imm_ext", id_imm_ext, mon_e.imm);
      end
    end
  end

  function automatic stim_t idle();
    stim_t t;
    t = '{rst: 1'b1, pc: fetch_pc, instr: 32'h0, ex_we: 1'b0, ex_ld: 1'b0, ex_rd: 5'd0,
          m_we: 1'b0, m_rd: 5'd0, m_data: 32'h0, w_we: 1'b0, w_addr: 5'd0, w_data: 32'h0};
    return t;
  endfunction

  function automatic logic [4:0] rreg();
    return ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rdata();
    return ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : 32'($urandom);
  endfunction

  function automatic logic [31:0] rinstr();
    logic [4:0]  a, b, c;
    logic [15:0] imm;
    a = rreg(); b = rreg(); c = rreg(); imm = 16'($urandom);
    case ($urandom_range(0, 11))
      0:  return {6'h00, a, b, c, 5'h0, 6'h21};
      1:  return {6'h00, a, b, c, 5'h0, 6'h23};
      2:  return {6'h0D, a, b, imm};
      3:  return {6'h0F, 5'h0, b, imm};
      4:  return {6'h23, a, b, imm};
      5:  return {6'h2B, a, b, imm};
      6:  return {6'h04, a, b, imm};
      7:  return {6'h02, 26'($urandom)};
      8:  return {6'h03, 26'($urandom)};
      9:  return {6'h00, a, 15'h0, 6'h08};
      10: return 32'h0;
      default: return 32'($urandom);
    endcase
  endfunction

  function automatic stim_t rstim();
    stim_t t;
    t = idle();
    t.rst    = ($urandom_range(0, 49) != 0);
    t.instr  = rinstr();
    t.ex_ld  = ($urandom_range(0, 3) == 0);
    t.ex_we  = t.ex_ld || ($urandom_range(0, 1) == 1);
    t.ex_rd  = rreg();
    t.m_we   = $urandom_range(0, 1) == 1;
    t.m_rd   = rreg();
    t.m_data = rdata();
    t.w_we   = $urandom_range(0, 1) == 1;
    t.w_addr = rreg();
    t.w_data = rdata();
    return t;
  endfunction

  initial begin
    s = idle(); s.rst = 1'b0; run(s); run(s);

    // WB write-through and $0 discard
    s = idle(); s.instr = {6'h00, 5'd8, 5'd0, 5'd3, 5'h0, 6'h21}; run(s);
    s = idle(); s.w_we = 1; s.w_addr = 8; s.w_data = 5;
    s.instr = {6'h00, 5'd0, 5'd0, 5'd3, 5'h0, 6'h21}; run(s);
    s = idle(); s.w_we = 1; s.w_addr = 0; s.w_data = 7; run(s);
    check("wb_bypass_rs", id_rs_data, 32'd5);
    s = idle(); run(s);
    check("reg0_reads_zero", id_rs_data, 32'd0);

    // beq with MEM-forwarded rs and WB-bypassed rt
    s = idle(); s.instr = {6'h04, 5'd1, 5'd2, 16'hFFFD}; run(s);
    s.m_we = 1; s.m_rd = 1; s.m_data = 4; s.w_we = 1; s.w_addr = 2; s.w_data = 4; run(s);
    check("beq_taken", 32'(isBranch), 32'd1);
    check("beq_target", branchAddr, 32'hFFFF_FFFD);
    s.w_data = 5; s.instr = 32'h0; run(s);
    check("beq_not_taken", 32'(isBranch), 32'd0);

    // j, then jr $31 with $31 written earlier
    s = idle(); s.instr = {6'h02, 26'h0000C04}; s.w_we = 1; s.w_addr = 31; s.w_data = 32'h3008; run(s);
    s = idle(); s.instr = {6'h00, 5'd31, 15'h0, 6'h08}; run(s);
    check("j_flag", 32'(isJump), 32'd1);
    check("j_target", 32'(jumpAddr), 32'h0000C04);
    s = idle(); run(s);
    check("jr_flag", 32'(isJumpReg), 32'd1);
    check("jr_target", jumpRegAddr, 32'h3008);

    // jr behind an EX producer: one stall, then redirect with the MEM value
    s = idle(); s.instr = {6'h00, 5'd4, 15'h0, 6'h08}; run(s);
    s = idle(); s.ex_we = 1; s.ex_rd = 4; run(s);
    check("jr_hazard_stall", 32'(stall), 32'd1);
    check("jr_hazard_noredirect", 32'(isJumpReg), 32'd0);
    s = idle(); s.m_we = 1; s.m_rd = 4; s.m_data = 32'h0000_4444; run(s);
    check("jr_after_stall", 32'(isJumpReg), 32'd1);
    check("jr_after_stall_addr", jumpRegAddr, 32'h0000_4444);

    // load-use: one bubble, IF/ID held
    s = idle(); s.instr = {6'h00, 5'd9, 5'd9, 5'd10, 5'h0, 6'h21}; run(s);
    s = idle(); s.ex_ld = 1; s.ex_we = 1; s.ex_rd = 9; run(s);
    check("load_use_stall", 32'(stall), 32'd1);
    s = idle(); run(s);
    check("load_use_released", 32'(stall), 32'd0);
    check("bubble_valid", 32'(id_valid), 32'd0);
    s = idle(); run(s);
    check("held_instr", id_instr, {6'h00, 5'd9, 5'd9, 5'd10, 5'h0, 6'h21});

    // reset while stalled
    s = idle(); s.instr = {6'h00, 5'd9, 5'd9, 5'd10, 5'h0, 6'h21}; run(s);
    s = idle(); s.ex_ld = 1; s.ex_we = 1; s.ex_rd = 9; s.rst = 0; run(s);
    s = idle(); s.instr = {6'h00, 5'd31, 5'd9, 5'd3, 5'h0, 6'h21}; run(s);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_no_redirect", 32'({isBranch, isJump, isJumpReg}), 32'd0);
    s = idle(); run(s);
    check("rst_ifid_pc", id_pc, PC_START);
    check("rst_ifid_instr", id_instr, 32'h0);
    s = idle(); run(s);
    check("rst_reg31_zero", id_rs_data, 32'h0);

    for (int n = 0; n < 3000; n++) run(rstim());

    s = idle(); run(s); run(s);
    repeat (2) @(negedge clk);
    #3;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
